// File: rtl/mem_responder.sv
// mem_responder: target side of the cpu memory port. Decodes mem_addr into
// byte-addressed RAM at address 0 and the timer MMIO window, returns load data
// and fault strobes in the same cycle, and commits stores on the next clk edge.
// Optional fault log registers are built when MEM_RESPONDER_FAULT_LOG_EN is
// defined; otherwise their addresses are unmapped.
module mem_responder #(
    parameter int unsigned RAM_BYTES = 65536,
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wd,
    output logic [31:0] mem_rd,
    input  logic [1:0]  mem_rd_unit,
    input  logic [1:0]  mem_wd_unit,
    input  logic [63:0] mtime,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtime_next,
    output logic [63:0] mtimecmp_next,
    output logic        mtime_we,
    output logic        access_fault,
    output logic        addr_misaligned
);

    localparam int AW = $clog2(RAM_BYTES);

    localparam logic [31:0] A_CMP_LO = MMIO_BASE + 32'h0000_4000;
    localparam logic [31:0] A_CMP_HI = MMIO_BASE + 32'h0000_4004;
    localparam logic [31:0] A_MT_LO  = MMIO_BASE + 32'h0000_BFF8;
    localparam logic [31:0] A_MT_HI  = MMIO_BASE + 32'h0000_BFFC;

    localparam logic [1:0] U_BYTE = 2'b00;
    localparam logic [1:0] U_HALF = 2'b01;
    localparam logic [1:0] U_WORD = 2'b10;
    localparam logic [1:0] U_RSVD = 2'b11;

    logic [7:0]    ram [RAM_BYTES];

    logic [1:0]    unit;
    logic          active;
    logic          mis;
    logic          fault;
    logic          ok;
    logic          is_ram;
    logic          sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic          sel_faddr, sel_fcnt;
    logic          sel_reg;
    logic [AW-1:0] ra;
    logic [31:0]   ram_rdata;
    logic          ram_we;
    logic [31:0]   flog_addr;
    logic [31:0]   flog_cnt;

    assign sel_cmp_lo = (mem_addr == A_CMP_LO);
    assign sel_cmp_hi = (mem_addr == A_CMP_HI);
    assign sel_mt_lo  = (mem_addr == A_MT_LO);
    assign sel_mt_hi  = (mem_addr == A_MT_HI);

`ifdef MEM_RESPONDER_FAULT_LOG_EN
    localparam logic [31:0] A_FADDR = MMIO_BASE + 32'h0000_8000;
    localparam logic [31:0] A_FCNT  = MMIO_BASE + 32'h0000_8004;

    assign sel_faddr = (mem_addr == A_FADDR);
    assign sel_fcnt  = (mem_addr == A_FCNT);

    // Fault log: latch the last faulting address and count faults (saturating).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flog_addr <= '0;
            flog_cnt  <= '0;
        end else if (active && (mis || fault)) begin
            flog_addr <= mem_addr;
            if (flog_cnt != 32'hFFFF_FFFF) flog_cnt <= flog_cnt + 32'd1;
        end else if (ok && mem_we && sel_fcnt) begin
            flog_cnt <= '0;
        end
    end
`else
    assign sel_faddr = 1'b0;
    assign sel_fcnt  = 1'b0;
    assign flog_addr = '0;
    assign flog_cnt  = '0;
`endif

    assign sel_reg = sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi | sel_faddr | sel_fcnt;
    assign ra      = mem_addr[AW-1:0];

    // Decode the access: active size, misalignment, then fault classification.
    always_comb begin
        unit   = mem_we ? mem_wd_unit : mem_rd_unit;
        active = mem_re | mem_we;
        is_ram = (mem_addr < RAM_BYTES);
        mis    = active && (((unit == U_HALF) && mem_addr[0]) ||
                            ((unit == U_WORD) && (mem_addr[1:0] != 2'b00)));
        fault  = active && !mis &&
                 ((unit == U_RSVD) || !(is_ram || sel_reg) ||
                  (sel_reg && (unit != U_WORD)) || (mem_we && sel_faddr));
        ok     = active && !mis && !fault;
        ram_we = reset && ok && mem_we && is_ram;
    end

    // Little-endian RAM read, zero-extended to the access size.
    always_comb begin
        ram_rdata = '0;
        case (unit)
            U_BYTE:  ram_rdata = {24'h0, ram[ra]};
            U_HALF:  ram_rdata = {16'h0, ram[ra + AW'(1)], ram[ra]};
            U_WORD:  ram_rdata = {ram[ra + AW'(3)], ram[ra + AW'(2)],
                                  ram[ra + AW'(1)], ram[ra]};
            default: ram_rdata = '0;
        endcase
    end

    // Byte-lane RAM write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ra] <= mem_wd[7:0];
            if (unit != U_BYTE) ram[ra + AW'(1)] <= mem_wd[15:8];
            if (unit == U_WORD) begin
                ram[ra + AW'(2)] <= mem_wd[23:16];
                ram[ra + AW'(3)] <= mem_wd[31:24];
            end
        end
    end

    // Load data mux; zero whenever the access is not a clean read.
    always_comb begin
        mem_rd = '0;
        if (reset && ok && mem_re) begin
            if (is_ram)          mem_rd = ram_rdata;
            else if (sel_cmp_lo) mem_rd = mtimecmp[31:0];
            else if (sel_cmp_hi) mem_rd = mtimecmp[63:32];
            else if (sel_mt_lo)  mem_rd = mtime[31:0];
            else if (sel_mt_hi)  mem_rd = mtime[63:32];
            else if (sel_faddr)  mem_rd = flog_addr;
            else if (sel_fcnt)   mem_rd = flog_cnt;
        end
    end

    // Timer register merge; the cpu holds mtime/mtimecmp, we only compute next values.
    always_comb begin
        mtime_next    = mtime;
        mtimecmp_next = mtimecmp;
        mtime_we      = 1'b0;
        if (reset && ok && mem_we) begin
            if (sel_mt_lo) begin
                mtime_next = {mtime[63:32], mem_wd};
                mtime_we   = 1'b1;
            end
            if (sel_mt_hi) begin
                mtime_next = {mem_wd, mtime[31:0]};
                mtime_we   = 1'b1;
            end
            if (sel_cmp_lo) mtimecmp_next = {mtimecmp[63:32], mem_wd};
            if (sel_cmp_hi) mtimecmp_next = {mem_wd, mtimecmp[31:0]};
        end
    end

    // Fault strobes are held low while reset is asserted.
    always_comb begin
        access_fault    = reset && fault;
        addr_misaligned = reset && mis;
    end

endmodule
